// File: rtl/prob_table_loader.sv
// Probability table loader: assembles a byte stream into fixed-width entries,
// writes them one per WRITE cycle to the downstream simulation system, checks
// that entries are non-decreasing, then releases (RUN) or holds (HALT) it.
module prob_table_loader #(
    parameter int unsigned N_ENTRIES   = 64,
    parameter int unsigned ENTRY_BYTES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [7:0]                 s_data,
    output logic [8*ENTRY_BYTES-1:0]   probability_in,
    output logic [31:0]                probability_idx,
    output logic                       sys_en,
    output logic                       sys_rstn,
    output logic                       busy,
    output logic                       load_done,
    output logic                       order_err,
    output logic [6:0]                 entry_count
);

    localparam int unsigned         W         = 8 * ENTRY_BYTES;
    localparam int unsigned         BCW       = (ENTRY_BYTES > 1) ? $clog2(ENTRY_BYTES) : 1;
    localparam logic [BCW-1:0]      LAST_BYTE = BCW'(ENTRY_BYTES - 1);
    localparam logic [6:0]          N_CNT     = 7'(N_ENTRIES);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
        StSettle,
        StRun,
        StHalt
    } state_e;

    state_e         state;
    logic [BCW-1:0] byte_cnt;
    logic [W-1:0]   word_q;
    logic [W-1:0]   word_next;
    logic [6:0]     next_count;
    logic           accept;

    assign accept = s_valid && s_ready;

    // Entry count never wraps past the table size.
    assign next_count = (entry_count == N_CNT) ? entry_count : entry_count + 7'd1;

    // Current partial word with the incoming byte dropped into lane byte_cnt.
    always_comb begin
        word_next = word_q;
        for (int b = 0; b < int'(ENTRY_BYTES); b++) begin
            if (byte_cnt == BCW'(b)) begin
                word_next[8*b +: 8] = s_data;
            end
        end
    end

    // Loader FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= StIdle;
            byte_cnt        <= '0;
            word_q          <= '0;
            s_ready         <= 1'b0;
            probability_idx <= 32'hFFFF_FFFF;
            probability_in  <= '0;
            sys_en          <= 1'b0;
            sys_rstn        <= 1'b0;
            busy            <= 1'b0;
            load_done       <= 1'b0;
            order_err       <= 1'b0;
            entry_count     <= '0;
        end else begin
            unique case (state)
                StIdle, StRun, StHalt: begin
                    if (load_start) begin
                        state       <= StLoad;
                        byte_cnt    <= '0;
                        word_q      <= '0;
                        entry_count <= '0;
                        order_err   <= 1'b0;
                        sys_en      <= 1'b0;
                        sys_rstn    <= 1'b0;
                        busy        <= 1'b1;
                        load_done   <= 1'b0;
                        s_ready     <= 1'b1;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        word_q <= word_next;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt        <= '0;
                            s_ready         <= 1'b0;
                            state           <= StWrite;
                            probability_idx <= 32'(entry_count);
                            probability_in  <= word_next;
                            // probability_in still holds the previous entry here.
                            if (entry_count != 7'd0 && word_next < probability_in) begin
                                order_err <= 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end
                StWrite: begin
                    entry_count     <= next_count;
                    probability_idx <= 32'hFFFF_FFFF;
                    if (next_count < N_CNT) begin
                        state   <= StLoad;
                        s_ready <= 1'b1;
                    end else begin
                        state <= StSettle;
                    end
                end
                StSettle: begin
                    busy      <= 1'b0;
                    load_done <= 1'b1;
                    if (order_err) begin
                        state <= StHalt;
                    end else begin
                        state    <= StRun;
                        sys_en   <= 1'b1;
                        sys_rstn <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_prob_table_loader.sv
// Directed bench for prob_table_loader: reset, full load, backpressured reload,
// ordering error to HALT, mid-load reset and fresh load.
module tb_prob_table_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [63:0] probability_in;
    logic [31:0] probability_idx;
    logic        sys_en;
    logic        sys_rstn;
    logic        busy;
    logic        load_done;
    logic        order_err;
    logic [6:0]  entry_count;

    int n_cmp = 0;
    int n_err = 0;

    prob_table_loader #(
        .N_ENTRIES   (64),
        .ENTRY_BYTES (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_start      (load_start),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .probability_in  (probability_in),
        .probability_idx (probability_idx),
        .sys_en          (sys_en),
        .sys_rstn        (sys_rstn),
        .busy            (busy),
        .load_done       (load_done),
        .order_err       (order_err),
        .entry_count     (entry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] entry_word(input int i, input bit err);
        if (err && i == 10) return 64'd0;
        return 64'(i) * 64'h0101;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 64'(s_ready), 0);
        check({tag, "_idx"}, 64'(probability_idx), 64'hFFFF_FFFF);
        check({tag, "_word"}, probability_in, 0);
        check({tag, "_sys_en"}, 64'(sys_en), 0);
        check({tag, "_sys_rstn"}, 64'(sys_rstn), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(load_done), 0);
        check({tag, "_oerr"}, 64'(order_err), 0);
        check({tag, "_count"}, 64'(entry_count), 0);
    endtask

    // Pulse load_start for one cycle; returns at the first LOAD-cycle negedge.
    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Stream the table; stop_bytes>0 aborts after that many accepted bytes.
    task automatic run_load(input bit gaps, input bit err, input int stop_bytes);
        int          ptr  = 0;
        int          exp  = 0;
        int          cyc  = 0;
        int          last = -1;
        logic [63:0] w;
        while (cyc < 4000) begin
            if (probability_idx !== 32'hFFFF_FFFF) begin
                check("idx", 64'(probability_idx), 64'(exp));
                check("word", probability_in, entry_word(exp, err));
                check("ready_in_write", 64'(s_ready), 0);
                if (!gaps && exp > 0) check("spacing", 64'(cyc - last), 9);
                if (err) check("order_err_at_write", 64'(order_err), 64'(exp >= 10));
                last = cyc;
                exp++;
            end
            if (load_done) break;
            if (stop_bytes > 0 && ptr == stop_bytes) begin
                s_valid = 1'b0;
                return;
            end
            s_valid    = (ptr < 512) && (!gaps || $urandom_range(1) == 1);
            w          = entry_word(ptr / 8, err);
            s_data     = w[8*(ptr%8) +: 8];
            load_start = (gaps && cyc == 20);
            if (s_valid && s_ready) ptr++;
            @(negedge clk);
            cyc++;
        end
        s_valid    = 1'b0;
        load_start = 1'b0;
        check("entries", 64'(exp), 64);
        check("last_write_to_done", 64'(cyc - last), 2);
        if (!gaps) check("load_time", 64'(cyc), 577);
        check("done", 64'(load_done), 1);
        check("end_sys_en", 64'(sys_en), 64'(!err));
        check("end_sys_rstn", 64'(sys_rstn), 64'(!err));
        check("end_busy", 64'(busy), 0);
        check("end_oerr", 64'(order_err), 64'(err));
        check("end_count", 64'(entry_count), 64);
        check("end_ready", 64'(s_ready), 0);
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        s_valid    = 1'b1;
        s_data     = 8'hAA;
        // Reset held 3 cycles with s_valid high; load_start during reset is ignored.
        @(negedge clk);
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(s_ready), 0);
        check("idle_busy", 64'(busy), 0);
        check("idle_idx", 64'(probability_idx), 64'hFFFF_FFFF);
        s_valid = 1'b0;

        // Full load with continuous s_valid.
        start_load();
        check("start_busy", 64'(busy), 1);
        check("start_ready", 64'(s_ready), 1);
        check("start_sys_rstn", 64'(sys_rstn), 0);
        check("start_count", 64'(entry_count), 0);
        run_load(0, 0, 0);

        // Reload from RUN with random gaps and an ignored mid-load load_start.
        start_load();
        check("reload_sys_en", 64'(sys_en), 0);
        check("reload_sys_rstn", 64'(sys_rstn), 0);
        check("reload_busy", 64'(busy), 1);
        check("reload_done", 64'(load_done), 0);
        run_load(1, 0, 0);

        // Entry 10 out of order: HALT.
        start_load();
        run_load(0, 1, 0);

        // Restart from HALT, abort with reset after 3 entries + 5 bytes.
        start_load();
        check("halt_restart_oerr", 64'(order_err), 0);
        check("halt_restart_done", 64'(load_done), 0);
        check("halt_restart_busy", 64'(busy), 1);
        run_load(0, 0, 29);
        check("midload_count", 64'(entry_count), 3);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midload_reset");
        rst = 1'b0;
        @(negedge clk);
        start_load();
        run_load(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
